fht_bank_loader: RTL and testbench
==================================

Name: fht_bank_loader

Overview:
Streaming front-end that writes a frame of ADC samples into the NUM_BANK-wide FHT working RAM, replacing testbench-driven direct bank writes. Samples are distributed round-robin across banks row by row. Row address is emitted in natural or bit-reversed order, so the same block serves initial FHT load and bit-reversed-to-natural reloads before IFHT. It sits between the ADC/reorder source and the iWE/iDATA/iADDR_WR write port of fht_top.

Parameters:
ADC_BIT, 16, width of the incoming signed sample.
D_BIT, 18, RAM word width; must be >= ADC_BIT + 1; samples are sign-extended to this width.
A_BIT, 8, bank address width; BANK_SIZE = 2**A_BIT rows.
NUM_BANK, 4, number of RAM banks; power of two, 2..16.

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous reset, active-high
iSTART  in  1  one-cycle pulse; arms a frame load when idle
iBIT_REV  in  1  address mode, sampled with iSTART: 0 natural, 1 bit-reversed row address
iVALID  in  1  input sample valid
iDATA  in  ADC_BIT  signed input sample
oREADY  out  1  loader accepts a sample this cycle
oWE  out  NUM_BANK  one-hot bank write enable to the FHT RAM
oADDR  out  A_BIT  row write address
oDATA  out  D_BIT  sign-extended sample
oBUSY  out  1  high from the accepted iSTART until oDONE
oDONE  out  1  one-cycle pulse after the last write of a frame

Behaviour:
- Reset, asynchronous and active-high: FSM=IDLE, counters=0, mode=0, oREADY=0, oWE=0, oADDR=0, oDATA=0, oBUSY=0, oDONE=0. Reset asserted mid-frame aborts the frame. No oDONE is produced, and the partial frame is not resumed.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - oREADY=0.
  - iSTART=1 latches iBIT_REV into mode, clears cnt_bank and cnt_row, sets oBUSY, and moves to LOAD.
- LOAD:
  - oREADY=1; iSTART is ignored.
  - A sample is accepted when iVALID & oREADY.
  - On accept, the registered outputs update the next cycle (1-cycle latency):
    - oWE = 1 << cnt_bank.
    - oADDR = mode ? bitrev_A_BIT(cnt_row) : cnt_row.
    - oDATA = {(D_BIT-ADC_BIT) copies of iDATA[ADC_BIT-1], iDATA}.
  - With no accept, oWE=0; oADDR and oDATA hold their last values.
  - Counters: after an accept, cnt_bank increments. When cnt_bank wraps from NUM_BANK-1 to 0, cnt_row increments.
  - An accept with cnt_row=BANK_SIZE-1 and cnt_bank=NUM_BANK-1 is the last sample. The FSM moves to FLUSH and oREADY drops the next cycle.
- FLUSH:
  - One cycle; the last write is presented on oWE/oADDR/oDATA.
  - Moves to DONE.
- DONE:
  - One cycle; oWE=0, oDONE=1, oBUSY=0 is registered for the next cycle.
  - Returns to IDLE. The earliest a new iSTART is accepted is the cycle after oDONE.
- Exactly NUM_BANK*BANK_SIZE writes occur per frame. Each (bank, address) pair is written exactly once, and oWE is never multi-hot.
- iVALID gaps of any length are allowed; the counters hold during gaps.
- Bit reversal: oADDR[A_BIT-1-k] = cnt_row[k] for all k.

Test Plan:
- Natural-order load (A_BIT=3, NUM_BANK=4): iSTART with iBIT_REV=0, then stream 32 samples 0..31 with iVALID held high.
  - Required: sample n gives oWE=1<<(n%4), oADDR=n/4, one cycle after accept.
  - Required: oDONE pulses exactly 2 cycles after the 32nd write and oBUSY then falls.
- Bit-reversed load (A_BIT=3): iBIT_REV=1, samples 0..31.
  - Required: row 1 writes go to oADDR=4, row 3 writes to oADDR=6, row 6 writes to oADDR=3.
- Sign extension (ADC_BIT=16, D_BIT=18):
  - iDATA=16'h8000 gives oDATA=18'h38000.
  - iDATA=16'h7FFF gives oDATA=18'h07FFF.
  - iDATA=16'hFFFF gives oDATA=18'h3FFFF.
- Valid gaps and start-in-LOAD: toggle iVALID randomly and pulse iSTART mid-frame.
  - Required: still exactly 32 writes, no write while iVALID=0, no counter restart.
- Reset mid-frame: assert iRESET after 10 accepts.
  - Required: all outputs become 0 asynchronously and no oDONE is produced.
  - Required: a new iSTART loads a full 32-sample frame beginning at oWE=4'b0001, oADDR=0.
- Back-to-back frames: issue iSTART in the cycle after oDONE.
  - Required: the second frame is accepted, with the counters restarting from row 0, bank 0.

Source files
------------

// File: rtl/fht_bank_loader.sv
// Purpose: streams one frame of ADC samples into the NUM_BANK-wide FHT RAM write port, round-robin across banks, with natural or bit-reversed row order.
// Latency: 1 cycle from an accepted sample to oWE/oADDR/oDATA; oDONE follows 2 cycles after the last write.
// Backpressure: oREADY is high only in LOAD; the source holds samples while oREADY=0, and iVALID gaps simply stall the counters.
module fht_bank_loader #(
  parameter int ADC_BIT  = 16,
  parameter int D_BIT    = 18,
  parameter int A_BIT    = 8,
  parameter int NUM_BANK = 4
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iSTART,
  input  logic                iBIT_REV,
  input  logic                iVALID,
  input  logic [ADC_BIT-1:0]  iDATA,
  output logic                oREADY,
  output logic [NUM_BANK-1:0] oWE,
  output logic [A_BIT-1:0]    oADDR,
  output logic [D_BIT-1:0]    oDATA,
  output logic                oBUSY,
  output logic                oDONE
);

  localparam int CB_BIT = $clog2(NUM_BANK);
  localparam logic [CB_BIT-1:0] LAST_BANK = CB_BIT'(NUM_BANK - 1);
  localparam logic [A_BIT-1:0]  LAST_ROW  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_mode;
  logic [CB_BIT-1:0]   r_cnt_bank;
  logic [A_BIT-1:0]    r_cnt_row;
  logic                r_ready;
  logic [NUM_BANK-1:0] r_we;
  logic [A_BIT-1:0]    r_addr;
  logic [D_BIT-1:0]    r_data;
  logic                r_busy;
  logic                r_done;

  logic                w_accept;
  logic                w_bank_wrap;
  logic                w_last;
  logic [A_BIT-1:0]    w_row_rev;
  logic [NUM_BANK-1:0] w_onehot;
  logic [D_BIT-1:0]    w_sext;

  // r_ready is only ever set while in LOAD, so it alone qualifies an accept
  assign w_accept    = r_ready & iVALID;
  assign w_bank_wrap = (r_cnt_bank == LAST_BANK);
  assign w_last      = w_accept & w_bank_wrap & (r_cnt_row == LAST_ROW);
  assign w_onehot    = {{(NUM_BANK-1){1'b0}}, 1'b1} << r_cnt_bank;
  assign w_sext      = {{(D_BIT-ADC_BIT){iDATA[ADC_BIT-1]}}, iDATA};

  // mirror the row counter bit order for bit-reversed addressing
  always_comb begin
    w_row_rev = '0;
    for (int k = 0; k < A_BIT; k++) begin
      w_row_rev[A_BIT-1-k] = r_cnt_row[k];
    end
  end

  // frame FSM, bank/row counters and all registered outputs
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_cnt_bank <= '0;
      r_cnt_row  <= '0;
      r_ready    <= 1'b0;
      r_we       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // write enable and done are single-cycle pulses unless re-asserted below
      r_we   <= '0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // a start landing on the oDONE cycle is ignored so frames never overlap the done pulse
          if (iSTART && !r_done) begin
            r_mode     <= iBIT_REV;
            r_cnt_bank <= '0;
            r_cnt_row  <= '0;
            r_busy     <= 1'b1;
            r_ready    <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_we       <= w_onehot;
            r_addr     <= r_mode ? w_row_rev : r_cnt_row;
            r_data     <= w_sext;
            r_cnt_bank <= r_cnt_bank + 1'b1;
            if (w_bank_wrap) begin
              r_cnt_row <= r_cnt_row + 1'b1;
            end
            if (w_last) begin
              r_ready <= 1'b0;
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // the final write is on the outputs during this cycle
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oREADY = r_ready;
  assign oWE    = r_we;
  assign oADDR  = r_addr;
  assign oDATA  = r_data;
  assign oBUSY  = r_busy;
  assign oDONE  = r_done;

endmodule

// File: tb/tb_fht_bank_loader.sv
// Directed bench for fht_bank_loader with A_BIT=3, NUM_BANK=4 (32-sample frames).
// Covers natural/bit-reversed order, sign extension, valid gaps, start during LOAD,
// reset abort and back-to-back frames.
module tb_fht_bank_loader;

  localparam int ADC_BIT  = 16;
  localparam int D_BIT    = 18;
  localparam int A_BIT    = 3;
  localparam int NUM_BANK = 4;
  localparam int NSAMP    = 32;

  // hand-computed 3-bit reversal: row r goes to address REV3[r]
  localparam logic [2:0] REV3 [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  // hand-computed one-hot per bank
  localparam logic [3:0] OH4  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  logic                iCLK;
  logic                iRESET;
  logic                iSTART;
  logic                iBIT_REV;
  logic                iVALID;
  logic [ADC_BIT-1:0]  iDATA;
  logic                oREADY;
  logic [NUM_BANK-1:0] oWE;
  logic [A_BIT-1:0]    oADDR;
  logic [D_BIT-1:0]    oDATA;
  logic                oBUSY;
  logic                oDONE;

  int n_pass;
  int n_total;

  logic [15:0] samples [NSAMP];
  logic [17:0] expd    [NSAMP];

  fht_bank_loader #(
    .ADC_BIT  (ADC_BIT),
    .D_BIT    (D_BIT),
    .A_BIT    (A_BIT),
    .NUM_BANK (NUM_BANK)
  ) dut (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .iSTART   (iSTART),
    .iBIT_REV (iBIT_REV),
    .iVALID   (iVALID),
    .iDATA    (iDATA),
    .oREADY   (oREADY),
    .oWE      (oWE),
    .oADDR    (oADDR),
    .oDATA    (oDATA),
    .oBUSY    (oBUSY),
    .oDONE    (oDONE)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic fill_counting(input int base);
    for (int i = 0; i < NSAMP; i++) begin
      samples[i] = 16'(base + i);
      expd[i]    = 18'(base + i);
    end
  endtask

  // One whole frame: start, stream all samples, check every write, then the flush/done tail.
  task automatic run_frame(input logic mode, input logic gaps, input logic mid_start);
    int         n;
    int         cyc;
    logic       v;
    logic [2:0] row;
    logic [2:0] exp_addr;
    logic [2:0] last_addr;
    logic [17:0] last_data;
    iBIT_REV = mode;
    iSTART   = 1'b1;
    tick();
    iSTART   = 1'b0;
    iBIT_REV = ~mode;  // mode must already be latched
    chk("busy_set", 32'(oBUSY), 32'd1);
    chk("ready_set", 32'(oREADY), 32'd1);
    n = 0;
    cyc = 0;
    last_addr = '0;
    last_data = '0;
    while (n < NSAMP && cyc < 400) begin
      v      = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      iVALID = v;
      iDATA  = v ? samples[n] : 16'($urandom);
      iSTART = mid_start && (n == 10);
      tick();
      cyc++;
      if (v) begin
        row      = 3'(n / 4);
        exp_addr = mode ? REV3[row] : row;
        chk("we", 32'(oWE), 32'(OH4[n % 4]));
        chk("addr", 32'(oADDR), 32'(exp_addr));
        chk("data", 32'(oDATA), 32'(expd[n]));
        last_addr = exp_addr;
        last_data = expd[n];
        n++;
      end else begin
        chk("gap_we", 32'(oWE), 32'd0);
        if (n > 0) begin
          chk("gap_addr_hold", 32'(oADDR), 32'(last_addr));
          chk("gap_data_hold", 32'(oDATA), 32'(last_data));
        end
      end
    end
    iVALID = 1'b0;
    iSTART = 1'b0;
    if (n < NSAMP) chk("frame_timeout", 32'(n), 32'(NSAMP));
    // FLUSH cycle: last write is on the outputs, no more samples accepted
    chk("ready_drop", 32'(oREADY), 32'd0);
    chk("busy_flush", 32'(oBUSY), 32'd1);
    tick();
    chk("we_after_last", 32'(oWE), 32'd0);
    chk("done_early", 32'(oDONE), 32'd0);
    tick();
    chk("done_pulse", 32'(oDONE), 32'd1);
    chk("busy_clear", 32'(oBUSY), 32'd0);
    // a start during the oDONE cycle must be refused
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    chk("done_one_cycle", 32'(oDONE), 32'd0);
    chk("start_on_done_refused", 32'(oBUSY), 32'd0);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    iRESET   = 1'b1;
    iSTART   = 1'b0;
    iBIT_REV = 1'b0;
    iVALID   = 1'b0;
    iDATA    = '0;

    // reset state
    tick();
    tick();
    chk("rst_ready", 32'(oREADY), 32'd0);
    chk("rst_we", 32'(oWE), 32'd0);
    chk("rst_addr", 32'(oADDR), 32'd0);
    chk("rst_data", 32'(oDATA), 32'd0);
    chk("rst_busy", 32'(oBUSY), 32'd0);
    chk("rst_done", 32'(oDONE), 32'd0);
    iRESET = 1'b0;
    tick();
    chk("idle_ready", 32'(oREADY), 32'd0);

    // natural order, samples 0..31
    fill_counting(0);
    run_frame(1'b0, 1'b0, 1'b0);

    // bit-reversed order, issued the cycle after oDONE
    run_frame(1'b1, 1'b0, 1'b0);

    // sign extension on the first three samples
    fill_counting(100);
    samples[0] = 16'h8000; expd[0] = 18'h38000;
    samples[1] = 16'h7FFF; expd[1] = 18'h07FFF;
    samples[2] = 16'hFFFF; expd[2] = 18'h3FFFF;
    run_frame(1'b0, 1'b0, 1'b0);

    // random valid gaps plus a start pulse mid-frame, signed random data
    for (int i = 0; i < NSAMP; i++) begin
      samples[i] = 16'($urandom);
      expd[i]    = 18'($signed(samples[i]));
    end
    run_frame(1'b1, 1'b1, 1'b0);
    run_frame(1'b0, 1'b1, 1'b1);

    // reset mid-frame after 10 accepts
    fill_counting(500);
    iBIT_REV = 1'b0;
    iSTART   = 1'b1;
    tick();
    iSTART = 1'b0;
    for (int i = 0; i < 10; i++) begin
      iVALID = 1'b1;
      iDATA  = samples[i];
      tick();
    end
    chk("pre_abort_we", 32'(oWE), 32'(4'b0010));
    chk("pre_abort_addr", 32'(oADDR), 32'd2);
    iVALID = 1'b0;
    #2;
    iRESET = 1'b1;
    #1;
    chk("abort_ready", 32'(oREADY), 32'd0);
    chk("abort_we", 32'(oWE), 32'd0);
    chk("abort_addr", 32'(oADDR), 32'd0);
    chk("abort_data", 32'(oDATA), 32'd0);
    chk("abort_busy", 32'(oBUSY), 32'd0);
    chk("abort_done", 32'(oDONE), 32'd0);
    tick();
    tick();
    iRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", 32'(oDONE), 32'd0);
      chk("abort_stays_idle", 32'(oBUSY), 32'd0);
    end

    // full frame after the abort starts again from bank 0, row 0
    run_frame(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
